// File: rtl/if_slice.sv
// ---------------------------------------------------------------------------
// if_slice -- instruction-fetch stage of the 16-bit 5-stage pipelined CPU.
//
// Owns the PC and the instruction-memory request/ready handshake, and
// produces the IF/ID pipeline register (instruction + PC+1) for decode.
// A one-entry skid buffer catches a word accepted from memory in the same
// cycle the hazard unit stalls. Bubbles are NOP_INSTR with valid=0.
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst_n        asynchronous active-low reset
//   stall        hazard unit: hold IF/ID register and PC
//   redirect     taken branch/call/ret: load redirect_pc, squash fetch
//   redirect_pc  redirect target (word address)
//   imem_req     fetch request to instruction memory
//   imem_addr    fetch word address (= pc)
//   imem_rdata   instruction data, valid when imem_rdy=1
//   imem_rdy     memory accepts/returns the request this cycle
//   instr        IF/ID instruction
//   PC_inc       IF/ID PC+1 of instr
//   valid        IF/ID holds a real instruction
//   halted       fetch stopped on HALT_INSTR
// ---------------------------------------------------------------------------
module if_slice #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'hF000,
  parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_rdy,
  output logic [15:0] instr,
  output logic [15:0] PC_inc,
  output logic        valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_inc_q, pc_inc_d;
  logic        valid_q, valid_d;
  logic [15:0] skid_instr_q, skid_instr_d;
  logic [15:0] skid_pc_inc_q, skid_pc_inc_d;
  logic        skid_valid_q, skid_valid_d;

  logic [15:0] pc_plus1;
  logic        accept;

  // Word addressing: the +1 simply wraps at 16 bits.
  assign pc_plus1 = pc_q + 16'd1;

  // Request is gated by rst_n so it drops the instant reset is asserted,
  // not at the next clock edge.
  assign imem_req  = rst_n & (state_q == FETCH);
  assign imem_addr = pc_q;
  assign accept    = imem_req & imem_rdy & ~redirect;

  assign instr  = instr_q;
  assign PC_inc = pc_inc_q;
  assign valid  = valid_q;
  assign halted = (state_q == HALT);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    pc_inc_d      = pc_inc_q;
    valid_d       = valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_inc_d = skid_pc_inc_q;
    skid_valid_d  = skid_valid_q;

    if (redirect) begin
      // Redirect beats stall, accept and HALT; any same-cycle memory
      // response is dropped because accept is masked above.
      pc_d         = redirect_pc;
      skid_valid_d = 1'b0;
      instr_d      = NOP_INSTR;
      pc_inc_d     = 16'h0000;
      valid_d      = 1'b0;
      state_d      = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (accept) begin
            pc_d = pc_plus1;
            if (!stall) begin
              instr_d  = imem_rdata;
              pc_inc_d = pc_plus1;
              valid_d  = 1'b1;
              if (imem_rdata == HALT_INSTR) begin
                state_d = HALT;
              end
            end else begin
              // Decode can't take it yet: park the word in the skid and
              // stop requesting until the stall clears.
              skid_instr_d  = imem_rdata;
              skid_pc_inc_d = pc_plus1;
              skid_valid_d  = 1'b1;
              state_d       = HOLD;
            end
          end else if (!stall) begin
            // IF/ID was consumed and nothing new arrived: insert a bubble.
            instr_d  = NOP_INSTR;
            pc_inc_d = 16'h0000;
            valid_d  = 1'b0;
          end
        end

        HOLD: begin
          if (!stall && skid_valid_q) begin
            instr_d      = skid_instr_q;
            pc_inc_d     = skid_pc_inc_q;
            valid_d      = 1'b1;
            skid_valid_d = 1'b0;
            state_d      = (skid_instr_q == HALT_INSTR) ? HALT : FETCH;
          end
        end

        HALT: begin
          // The halt word stays in IF/ID until decode takes it; after that
          // only bubbles until a redirect or reset.
          if (!stall) begin
            instr_d  = NOP_INSTR;
            pc_inc_d = 16'h0000;
            valid_d  = 1'b0;
          end
        end

        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      pc_inc_q      <= 16'h0000;
      valid_q       <= 1'b0;
      skid_instr_q  <= NOP_INSTR;
      skid_pc_inc_q <= 16'h0000;
      skid_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pc_inc_q      <= pc_inc_d;
      valid_q       <= valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_inc_q <= skid_pc_inc_d;
      skid_valid_q  <= skid_valid_d;
    end
  end

endmodule

// File: tb/tb_if_slice.sv
module tb_if_slice;

  localparam logic [15:0] NOP  = 16'hF000;
  localparam logic [15:0] HALT = 16'hFFFF;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_rdy;
  logic [15:0] instr;
  logic [15:0] PC_inc;
  logic        valid;
  logic        halted;

  // memory model controls
  logic        halt_en;
  logic [15:0] halt_addr;

  int total;
  int bad;

  logic [31:0] sb[$];
  logic [31:0] exp_w;

  if_slice dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_rdy   (imem_rdy),
    .instr      (instr),
    .PC_inc     (PC_inc),
    .valid      (valid),
    .halted     (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem_model(input logic [15:0] a, input logic he,
                                            input logic [15:0] ha);
    if (he && a == ha) return HALT;
    return 16'h1000 + a;
  endfunction

  always_comb imem_rdata = mem_model(imem_addr, halt_en, halt_addr);

  // Scoreboard: every accepted word is pushed in order; it is popped when
  // decode consumes IF/ID (valid & !stall). Redirect/reset flush it.
  always @(negedge clk) begin
    if (!rst_n || redirect) begin
      sb.delete();
    end else begin
      if (!valid) begin
        total++;
        if (instr !== NOP) begin
          bad++;
          $display("FAIL sb_bubble: instr=%h required %h", instr, NOP);
        end
      end
      if (valid && !stall) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_spurious_valid: instr=%h PC_inc=%h with nothing expected", instr, PC_inc);
        end else begin
          exp_w = sb.pop_front();
          if ({instr, PC_inc} !== exp_w) begin
            bad++;
            $display("FAIL sb_consume: instr=%h PC_inc=%h required instr=%h PC_inc=%h",
                     instr, PC_inc, exp_w[31:16], exp_w[15:0]);
          end else begin
            $display("txn consumed instr=%h PC_inc=%h", instr, PC_inc);
          end
        end
      end
      if (imem_req && imem_rdy) begin
        sb.push_back({mem_model(imem_addr, halt_en, halt_addr), imem_addr + 16'd1});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [15:0] tgt);
    redirect    = 1'b1;
    redirect_pc = tgt;
    cyc();
    redirect    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    imem_rdy = 1'b1; halt_en = 1'b0; halt_addr = 16'h0;
    #1 rst_n = 1'b0;
    cyc(); cyc();
    total++;
    if (imem_req !== 1'b0 || instr !== NOP || PC_inc !== 16'h0 || valid !== 1'b0 ||
        halted !== 1'b0 || imem_addr !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: req=%b addr=%h instr=%h PC_inc=%h valid=%b halted=%b required 0 0000 f000 0000 0 0",
               imem_req, imem_addr, instr, PC_inc, valid, halted);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin
      bad++;
      $display("FAIL reset_release: req=%b addr=%h required 1 0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (imem_addr !== 16'(i)) begin
        bad++;
        $display("FAIL stream_addr: addr=%h required %h", imem_addr, 16'(i));
      end
      cyc();
      total++;
      if (instr !== 16'h1000 + 16'(i) || PC_inc !== 16'(i + 1) || valid !== 1'b1) begin
        bad++;
        $display("FAIL stream_ifid: instr=%h PC_inc=%h valid=%b required %h %h 1",
                 instr, PC_inc, valid, 16'h1000 + 16'(i), 16'(i + 1));
      end
    end
  endtask

  task automatic test_stall();
    cyc();  // accept addr 4
    stall = 1'b1;
    total++;
    if (imem_addr !== 16'h5 || imem_req !== 1'b1) begin
      bad++;
      $display("FAIL stall_pre: addr=%h req=%b required 0005 1", imem_addr, imem_req);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (instr !== 16'h1004 || PC_inc !== 16'h5 || valid !== 1'b1 || imem_req !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold: instr=%h PC_inc=%h valid=%b req=%b required 1004 0005 1 0",
                 instr, PC_inc, valid, imem_req);
      end
    end
    stall = 1'b0;
    cyc();
    total++;
    if (instr !== 16'h1005 || PC_inc !== 16'h6 || valid !== 1'b1 || imem_req !== 1'b1 ||
        imem_addr !== 16'h6) begin
      bad++;
      $display("FAIL stall_release: instr=%h PC_inc=%h valid=%b req=%b addr=%h required 1005 0006 1 1 0006",
               instr, PC_inc, valid, imem_req, imem_addr);
    end
    cyc();
    total++;
    if (instr !== 16'h1006 || PC_inc !== 16'h7) begin
      bad++;
      $display("FAIL stall_resume: instr=%h PC_inc=%h required 1006 0007", instr, PC_inc);
    end
  endtask

  task automatic test_rdy_low();
    imem_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h7 || valid !== 1'b0 || instr !== NOP) begin
        bad++;
        $display("FAIL rdy_low_wait: req=%b addr=%h valid=%b instr=%h required 1 0007 0 f000",
                 imem_req, imem_addr, valid, instr);
      end
    end
    imem_rdy = 1'b1;
    cyc();
    total++;
    if (instr !== 16'h1007 || PC_inc !== 16'h8 || valid !== 1'b1) begin
      bad++;
      $display("FAIL rdy_low_resume: instr=%h PC_inc=%h valid=%b required 1007 0008 1",
               instr, PC_inc, valid);
    end
  endtask

  task automatic test_redirect();
    cyc();  // accept addr 8, pc now 9
    do_redirect(16'h0040);  // same cycle as rdy for addr 9
    total++;
    if (instr !== NOP || valid !== 1'b0 || PC_inc !== 16'h0 || imem_addr !== 16'h0040 ||
        imem_req !== 1'b1) begin
      bad++;
      $display("FAIL redirect_flush: instr=%h valid=%b PC_inc=%h addr=%h req=%b required f000 0 0000 0040 1",
               instr, valid, PC_inc, imem_addr, imem_req);
    end
    cyc();
    total++;
    if (instr !== 16'h1040 || PC_inc !== 16'h0041 || valid !== 1'b1) begin
      bad++;
      $display("FAIL redirect_target: instr=%h PC_inc=%h valid=%b required 1040 0041 1",
               instr, PC_inc, valid);
    end
  endtask

  task automatic test_halt();
    halt_en = 1'b1; halt_addr = 16'h3;
    do_redirect(16'h0000);
    cyc(); cyc(); cyc();  // addresses 0,1,2
    total++;
    if (imem_addr !== 16'h3) begin
      bad++;
      $display("FAIL halt_addr: addr=%h required 0003", imem_addr);
    end
    cyc();  // accept halt word
    total++;
    if (instr !== HALT || valid !== 1'b1 || PC_inc !== 16'h4 || halted !== 1'b1 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL halt_deliver: instr=%h valid=%b PC_inc=%h halted=%b req=%b required ffff 1 0004 1 0",
               instr, valid, PC_inc, halted, imem_req);
    end
    stall = 1'b1;
    cyc();
    total++;
    if (instr !== HALT || valid !== 1'b1 || halted !== 1'b1) begin
      bad++;
      $display("FAIL halt_stall_hold: instr=%h valid=%b halted=%b required ffff 1 1", instr, valid, halted);
    end
    stall = 1'b0;
    cyc();
    total++;
    if (instr !== NOP || valid !== 1'b0 || halted !== 1'b1 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL halt_bubble: instr=%h valid=%b halted=%b req=%b required f000 0 1 0",
               instr, valid, halted, imem_req);
    end
    // halt word arriving through the skid buffer
    do_redirect(16'h0002);
    cyc();  // accept addr 2
    stall = 1'b1;
    cyc();  // halt word into skid
    total++;
    if (instr !== 16'h1002 || imem_req !== 1'b0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_skid_hold: instr=%h req=%b halted=%b required 1002 0 0", instr, imem_req, halted);
    end
    stall = 1'b0;
    cyc();
    total++;
    if (instr !== HALT || valid !== 1'b1 || PC_inc !== 16'h4 || halted !== 1'b1 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL halt_skid_deliver: instr=%h valid=%b PC_inc=%h halted=%b req=%b required ffff 1 0004 1 0",
               instr, valid, PC_inc, halted, imem_req);
    end
    cyc();
    do_redirect(16'h0010);
    halt_en = 1'b0;
    total++;
    if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0010 || valid !== 1'b0) begin
      bad++;
      $display("FAIL halt_exit: halted=%b req=%b addr=%h valid=%b required 0 1 0010 0",
               halted, imem_req, imem_addr, valid);
    end
    cyc();
    total++;
    if (instr !== 16'h1010 || PC_inc !== 16'h0011 || valid !== 1'b1) begin
      bad++;
      $display("FAIL halt_resume: instr=%h PC_inc=%h valid=%b required 1010 0011 1", instr, PC_inc, valid);
    end
  endtask

  task automatic test_wrap();
    do_redirect(16'hFFFF);
    cyc();
    total++;
    if (instr !== 16'h0FFF || PC_inc !== 16'h0000 || valid !== 1'b1 || imem_addr !== 16'h0000) begin
      bad++;
      $display("FAIL wrap: instr=%h PC_inc=%h valid=%b addr=%h required 0fff 0000 1 0000",
               instr, PC_inc, valid, imem_addr);
    end
  endtask

  task automatic test_stall_empty_and_reset();
    do_redirect(16'h0030);
    stall = 1'b1; imem_rdy = 1'b0;
    cyc(); cyc();
    total++;
    if (valid !== 1'b0 || instr !== NOP || imem_req !== 1'b1 || imem_addr !== 16'h0030) begin
      bad++;
      $display("FAIL stall_empty: valid=%b instr=%h req=%b addr=%h required 0 f000 1 0030",
               valid, instr, imem_req, imem_addr);
    end
    stall = 1'b0; imem_rdy = 1'b1;
    cyc();
    stall = 1'b1;
    cyc();  // addr 0x31 parked in skid
    total++;
    if (instr !== 16'h1030 || valid !== 1'b1 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL pre_reset_hold: instr=%h valid=%b req=%b required 1030 1 0", instr, valid, imem_req);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (instr !== NOP || valid !== 1'b0 || PC_inc !== 16'h0 || imem_req !== 1'b0 ||
        imem_addr !== 16'h0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_stall: instr=%h valid=%b PC_inc=%h req=%b addr=%h halted=%b required f000 0 0000 0 0000 0",
               instr, valid, PC_inc, imem_req, imem_addr, halted);
    end
    @(negedge clk);
    cyc();
    rst_n = 1'b1; stall = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_restart: req=%b addr=%h valid=%b required 1 0000 0", imem_req, imem_addr, valid);
    end
    cyc();
    total++;
    if (instr !== 16'h1000 || PC_inc !== 16'h1 || valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_refetch: instr=%h PC_inc=%h valid=%b required 1000 0001 1", instr, PC_inc, valid);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_stream();
    test_stall();
    test_rdy_low();
    test_redirect();
    test_halt();
    test_wrap();
    test_stall_empty_and_reset();
    cyc(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_slice.md
Name: if_slice

Overview:
- Instruction-fetch stage of the 16-bit, 5-stage pipelined CPU.
- Owns the PC register and the instruction-memory request/ready handshake. Produces the IF/ID pipeline register (instruction and PC+1) consumed by the decode stage.
- Handles stalls from the hazard unit, redirects from branch/call/return resolution, and halt detection. Bubbles are injected as the flush opcode, which decode treats as a no-op.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'hF000, bubble instruction (opcode F = flush/no-op in decode)
HALT_INSTR, 16'hFFFF, instruction encoding that halts fetch

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hazard unit: hold IF/ID register and PC
redirect  in  1  taken branch/call/ret: load redirect_pc, squash fetch
redirect_pc  in  16  redirect target (word address)
imem_req  out  1  fetch request to instruction memory
imem_addr  out  16  fetch word address (= pc)
imem_rdata  in  16  instruction data, valid when imem_rdy=1
imem_rdy  in  1  memory accepts/returns the request this cycle
instr  out  16  IF/ID instruction
PC_inc  out  16  IF/ID PC+1 of instr
valid  out  1  IF/ID holds a real instruction
halted  out  1  fetch stopped on HALT_INSTR

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_PC, instr=NOP_INSTR, PC_inc=0, valid=0.
  - skid buffer empty; state=FETCH; halted=0.
  - imem_req is 0 while rst_n=0.
- States: FETCH, HOLD, HALT.
- Addressing: word addressed; pc+1 wraps 16'hFFFF -> 16'h0000, no carry out.
- FETCH:
  - imem_req=1, imem_addr=pc; both held stable until imem_rdy is sampled 1.
  - Zero-wait memory is allowed: rdy may rise in the same cycle as req.
- Accept = posedge with imem_req & imem_rdy & !redirect. On accept:
  - pc <= pc+1.
  - If !stall: instr<=imem_rdata, PC_inc<=pc+1, valid<=1.
  - If stall: {imem_rdata, pc+1} go into the 1-entry skid; state<=HOLD.
  - If imem_rdata==HALT_INSTR: state<=HALT after the halt word is delivered, either directly or via the skid.
- HOLD:
  - imem_req=0.
  - When stall=0: IF/ID <= skid, valid<=1, skid empties, state<=FETCH (or HALT if the skid word is HALT_INSTR).
- HALT:
  - imem_req=0, halted=1.
  - IF/ID keeps the halt word until !stall. On the following non-stalled cycle it loads NOP_INSTR with valid=0.
  - HALT is left only by redirect or reset.
- stall with no accept: IF/ID, pc and state hold.
  - Throughput is 1 instr/cycle when imem_rdy is held 1 and stall=0.
- Redirect has highest priority (overrides stall, accept and HALT). At the posedge:
  - pc<=redirect_pc; skid emptied.
  - instr<=NOP_INSTR, valid<=0, PC_inc<=0.
  - halted<=0; state<=FETCH.
  - A same-cycle imem_rdy response is discarded. The next request uses redirect_pc in the following cycle.
- Stall while empty: stall=1 with valid=0 keeps the bubble; no spurious valid.
- Reset mid-fetch: the request drops immediately and the fetch restarts at RESET_PC on the first posedge after rst_n rises.
- IF/ID latency: one cycle from accept to instr/valid visible.

Test Plan:
- Reset release, imem_rdy=1 constant, memory[i]=16'h1000+i:
  - imem_addr 0,1,2,3 on consecutive cycles.
  - instr 1000,1001,1002 one cycle later, PC_inc 1,2,3, valid=1.
- Stall for 3 cycles while a fetch of addr 5 is accepted:
  - IF/ID holds addr-4 word; skid captures 1005.
  - imem_req=0 during HOLD.
  - After release, instr=1005, PC_inc=6, then addr 6 is fetched.
- Redirect to 16'h0040 in the same cycle as imem_rdy for addr 9:
  - Data for addr 9 is discarded; next cycle instr=F000, valid=0.
  - imem_addr=0040; then instr=mem[40], PC_inc=41.
- imem_rdy low for 4 cycles at addr 7:
  - imem_req=1 and imem_addr=7 stable throughout; valid drops to 0 only if IF/ID was consumed (bubble F000).
  - Resumes on rdy.
- mem[3]=16'hFFFF:
  - instr=FFFF valid=1 delivered, then halted=1, imem_req=0, next instr=F000.
  - A redirect to 16'h0010 clears halted and resumes fetch at 0010.
- pc=16'hFFFF accepted:
  - PC_inc=16'h0000 and the next imem_addr=0000.
- rst_n pulsed low mid-stall:
  - All outputs return immediately to reset values.
